// File: rtl/utxd_crc_frm_if.sv
// Frame-transmitter bundle: command/strobe inputs, memory read port,
// serial line and status. clk/res_n stay plain ports on the block.
interface utxd_crc_frm_if;
  logic        st;
  logic [7:0]  com;
  logic [15:0] adr;
  logic [7:0]  lbl;
  logic [7:0]  dat;
  logic [15:0] rd_adr;
  logic        UTXD;
  logic        en_tx;
  logic        busy;
  logic        done;
  logic [7:0]  cb_byte;
  logic [15:0] CRC;

  modport master (
    output st, com, adr, lbl, dat,
    input  rd_adr, UTXD, en_tx, busy,
    input  done, cb_byte, CRC
  );

  modport slave (
    input  st, com, adr, lbl, dat,
    output rd_adr, UTXD, en_tx, busy,
    output done, cb_byte, CRC
  );
endinterface

// File: rtl/utxd_crc_frm.sv
// CRC-16/CCITT framed UART transmitter: com, adr, lbl, data, CRC.
// Define TX_PARITY_EN for 8E1 framing; default build is 8N1.
module utxd_crc_frm #(
  parameter int          BIT_DIV  = 434,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input logic           clk,
  input logic           res_n,
  utxd_crc_frm_if.slave bus
);

  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_END = DW'(BIT_DIV - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  lbl_q, lbl_d;
  logic [15:0] rd_q, rd_d;
  logic [15:0] crc_q, crc_d;
  logic        done_q, done_d;
  logic        line_q, line_d;
`ifdef TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        bit_end;
  logic [8:0]  d_end;
  logic [8:0]  last;
  logic [8:0]  nx;
  logic [7:0]  nb;
  logic        nx_data;
  logic        nx_crc;

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021)
                : {r[14:0], 1'b0};
    return r;
  endfunction

  assign bit_end = (div_q == DIV_END);
  assign d_end   = {1'b0, lbl_q} + 9'd4;
  assign last    = d_end + 9'd1;

  // Source of the byte that follows the one on the line
  always_comb begin
    nx      = idx_q + 9'd1;
    nb      = 8'h00;
    nx_data = 1'b0;
    nx_crc  = 1'b0;
    unique case (1'b1)
      nx == 9'd1: nb = adr_q[15:8];
      nx == 9'd2: nb = adr_q[7:0];
      nx == 9'd3: nb = lbl_q;
      (nx >= 9'd4) && (nx < d_end): begin
        nb      = bus.dat;
        nx_data = 1'b1;
      end
      nx == d_end: begin
        nb     = crc_q[15:8];
        nx_crc = 1'b1;
      end
      default: begin
        nb     = crc_q[7:0];
        nx_crc = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    lbl_d   = lbl_q;
    rd_d    = rd_q;
    crc_d   = crc_q;
    done_d  = 1'b0;
    line_d  = 1'b1;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE)
      div_d = bit_end ? '0 : div_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.st) begin
          adr_d   = bus.adr;
          lbl_d   = bus.lbl;
          rd_d    = bus.adr;
          crc_d   = crc_byte(CRC_INIT, bus.com);
          sh_d    = bus.com;
          idx_d   = '0;
          div_d   = '0;
          state_d = START;
`ifdef TX_PARITY_EN
          par_d   = ^bus.com;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      PAR: begin
        if (bit_end)
          state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == last) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            idx_d   = nx;
            sh_d    = nb;
            // CRC bytes themselves are not folded in
            if (!nx_crc)
              crc_d = crc_byte(crc_q, nb);
            if (nx_data)
              rd_d = rd_q + 16'd1;
`ifdef TX_PARITY_EN
            par_d = ^nb;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = sh_d[0];
`ifdef TX_PARITY_EN
      PAR:     line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      adr_q   <= '0;
      lbl_q   <= '0;
      rd_q    <= '0;
      crc_q   <= CRC_INIT;
      done_q  <= 1'b0;
      line_q  <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      lbl_q   <= lbl_d;
      rd_q    <= rd_d;
      crc_q   <= crc_d;
      done_q  <= done_d;
      line_q  <= line_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.UTXD    = line_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.en_tx   = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.cb_byte = idx_q[7:0];
  assign bus.rd_adr  = rd_q;
  assign bus.CRC     = crc_q;

endmodule

// File: tb/tb_utxd_crc_frm.sv
// Bench for utxd_crc_frm: UART decoder monitor against an
// expected-byte queue filled when each frame is issued.
module tb_utxd_crc_frm;

  localparam int BD = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] b;
    logic [7:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;
  exp_t q[$];
  logic [7:0] mem [0:65535];

  utxd_crc_frm_if bus();

  utxd_crc_frm #(
    .BIT_DIV  (BD),
    .CRC_INIT (16'hFFFF)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.dat <= mem[bus.rd_adr];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bit-serial CCITT reference
  function automatic logic [15:0] mcrc(input logic [15:0] c,
                                       input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic push(input logic [7:0] b, input logic [7:0] idx);
    exp_t e;
    e.b   = b;
    e.idx = idx;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] c,
                            input logic [15:0] a,
                            input logic [7:0] n);
    logic [15:0] crc;
    logic [7:0]  hdr [4];
    logic [15:0] ad;
    crc = 16'hFFFF;
    hdr[0] = c;
    hdr[1] = a[15:8];
    hdr[2] = a[7:0];
    hdr[3] = n;
    for (int i = 0; i < 4; i++) begin
      push(hdr[i], 8'(i));
      crc = mcrc(crc, hdr[i]);
    end
    for (int j = 0; j < int'(n); j++) begin
      ad = a + 16'(j);
      push(mem[ad], 8'(j + 4));
      crc = mcrc(crc, mem[ad]);
    end
    push(crc[15:8], n + 8'd4);
    push(crc[7:0], n + 8'd5);
  endtask

  task automatic issue(input logic [7:0] c,
                       input logic [15:0] a,
                       input logic [7:0] n,
                       output int t0);
    bus.com = c;
    bus.adr = a;
    bus.lbl = n;
    bus.st  = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    t0 = cyc;
    chk("lat_en_tx", bus.en_tx, 1);
    chk("lat_utxd", bus.UTXD, 0);
    chk("lat_busy", bus.busy, 1);
  endtask

  task automatic wait_done(input int t0, input int f,
                           input string nm);
    do @(negedge clk);
    while (!bus.done && (cyc - t0) <= f + 40);
    chk({nm, "_len"}, cyc - t0, f);
    chk({nm, "_en_tx"}, bus.en_tx, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_cb"}, bus.cb_byte, 0);
  endtask

  task automatic wait_cb(input logic [7:0] v);
    int n;
    n = 0;
    while (bus.cb_byte != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_cb", bus.cb_byte, v);
  endtask

  task automatic tick(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (!res_n) ab = 1'b1;
    end
  endtask

  // Monitor: decode every byte the DUT puts on the line
  initial begin
    logic [7:0] b;
    logic [7:0] idx;
    logic       s;
    bit         ab;
    exp_t       e;
`ifdef TX_PARITY_EN
    logic       p;
`endif
    forever begin
      @(negedge clk);
      if (res_n && bus.UTXD === 1'b0) begin
        ab = 1'b0;
        tick(BD / 2, ab);
        idx = bus.cb_byte;
        for (int i = 0; i < 8; i++) begin
          tick(BD, ab);
          b[i] = bus.UTXD;
        end
`ifdef TX_PARITY_EN
        tick(BD, ab);
        p = bus.UTXD;
`endif
        tick(BD, ab);
        s = bus.UTXD;
        if (!ab) begin
          if (q.size() == 0) begin
            chk("extra_byte", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("byte", b, e.b);
            chk("cb_byte", idx, e.idx);
            chk("stop", s, 1);
`ifdef TX_PARITY_EN
            chk("parity", p, ^e.b);
`endif
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 13 + 5);
    bus.st  = 1'b0;
    bus.com = '0;
    bus.adr = '0;
    bus.lbl = '0;
    repeat (3) @(negedge clk);
    chk("rst_utxd", bus.UTXD, 1);
    chk("rst_en_tx", bus.en_tx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cb", bus.cb_byte, 0);
    chk("rst_rd", bus.rd_adr, 0);
    chk("rst_crc", bus.CRC, 16'hFFFF);
    res_n = 1'b1;
    @(negedge clk);

    // Header only
    push_frame(8'hA5, 16'h1234, 8'd0);
    issue(8'hA5, 16'h1234, 8'd0, t0);
    wait_done(t0, 6 * NB * BD, "hdr");
    chk("hdr_rd", bus.rd_adr, 16'h1234);
    @(negedge clk);
    chk("hdr_pulse", bus.done, 0);

    // Three data bytes
    mem[16'h0010] = 8'h11;
    mem[16'h0011] = 8'h22;
    mem[16'h0012] = 8'h33;
    push_frame(8'h3C, 16'h0010, 8'd3);
    issue(8'h3C, 16'h0010, 8'd3, t0);
    wait_done(t0, 9 * NB * BD, "d3");
    chk("d3_rd", bus.rd_adr, 16'h0013);
    @(negedge clk);

    // Address wrap, com 0x07 (odd parity weight)
    mem[16'hFFFE] = 8'hA1;
    mem[16'hFFFF] = 8'hB2;
    mem[16'h0000] = 8'hC3;
    mem[16'h0001] = 8'hD4;
    push_frame(8'h07, 16'hFFFE, 8'd4);
    issue(8'h07, 16'hFFFE, 8'd4, t0);
    wait_done(t0, 10 * NB * BD, "wrap");
    chk("wrap_rd", bus.rd_adr, 16'h0002);
    @(negedge clk);

    // st while busy ignored, then held through done
    push_frame(8'h5A, 16'h0100, 8'd0);
    issue(8'h5A, 16'h0100, 8'd0, t0);
    wait_cb(8'd2);
    bus.com = 8'hFF;
    bus.adr = 16'h0400;
    bus.lbl = 8'd7;
    bus.st  = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    wait_cb(8'd5);
    mem[16'h0200] = 8'h42;
    push_frame(8'h69, 16'h0200, 8'd1);
    bus.com = 8'h69;
    bus.adr = 16'h0200;
    bus.lbl = 8'd1;
    bus.st  = 1'b1;
    wait_done(t0, 6 * NB * BD, "bsy");
    @(negedge clk);
    bus.st = 1'b0;
    t0 = cyc;
    chk("b2b_done", bus.done, 0);
    chk("b2b_en_tx", bus.en_tx, 1);
    chk("b2b_utxd", bus.UTXD, 0);
    wait_done(t0, 7 * NB * BD, "b2b");
    chk("b2b_rd", bus.rd_adr, 16'h0201);
    @(negedge clk);

    // Reset mid-frame
    mem[16'h0300] = 8'h5E;
    mem[16'h0301] = 8'h6F;
    push_frame(8'hE1, 16'h0300, 8'd2);
    issue(8'hE1, 16'h0300, 8'd2, t0);
    wait_cb(8'd3);
    repeat (5) @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("abort_utxd", bus.UTXD, 1);
    chk("abort_en_tx", bus.en_tx, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_crc", bus.CRC, 16'hFFFF);
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", bus.done, 0);
    end
    res_n = 1'b1;
    @(negedge clk);
    push_frame(8'hE1, 16'h0300, 8'd2);
    issue(8'hE1, 16'h0300, 8'd2, t0);
    wait_done(t0, 8 * NB * BD, "post");
    chk("post_rd", bus.rd_adr, 16'h0302);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
